// File: rtl/bsc_pkg.sv
// Boundary-scan sequencer shared definitions: FSM state encoding, control bus
// bit indices (shared with the chain integration) and the control decoder.
package bsc_pkg;

  localparam int unsigned BSC_CTL_W = 4;
  localparam int unsigned BSC_CAP   = 0;
  localparam int unsigned BSC_SHF   = 1;
  localparam int unsigned BSC_UPD   = 2;
  localparam int unsigned BSC_MODE  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAP1  = 3'd1,
    CAP2  = 3'd2,
    SHIFT = 3'd3,
    UPD   = 3'd4,
    DONE  = 3'd5
  } bsc_state_e;

  // Control bus value presented to the chain while in state st.
  function automatic logic [BSC_CTL_W-1:0] bsc_ctl(input bsc_state_e st, input logic mode);
    logic [BSC_CTL_W-1:0] c;
    c           = '0;
    c[BSC_MODE] = mode;
    case (st)
      CAP1, CAP2: c[BSC_CAP] = 1'b1;
      SHIFT:      c[BSC_SHF] = 1'b1;
      UPD:        c[BSC_UPD] = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bscan_sequencer.sv
// Sequences one boundary-scan DR operation (capture x2 -> shift -> update)
// from a start/done handshake. Parallel-in/parallel-out front end to the chain.
// Ports:
//   tck, reset_n          scan clock, async active-low reset
//   start, test_mode_req  operation request and its mode (latched on accept)
//   abort                 abandon operation before update (reports err)
//   wr_data / rd_data     pattern to load / captured chain contents
//   busy, done, err       status (done is a 1-cycle pulse, err qualifies it)
//   bsc_control           to chain: [0] capture [1] shift [2] update [3] mode
//   bsc_tdi / bsc_tdo     serial data to cell 0 / from last cell
module bscan_sequencer
  import bsc_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 32
) (
  input  logic                    tck,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    test_mode_req,
  input  logic                    abort,
  input  logic [CHAIN_LENGTH-1:0] wr_data,
  output logic [CHAIN_LENGTH-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [BSC_CTL_W-1:0]    bsc_control,
  output logic                    bsc_tdi,
  input  logic                    bsc_tdo
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int unsigned IDX_W = $clog2(CHAIN_LENGTH);

  bsc_state_e              state_q, state_d;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LENGTH-1:0] wr_q;
  logic                    accept;
  logic                    last_bit;
  logic [IDX_W-1:0]        tdi_idx;
  logic [IDX_W-1:0]        rd_idx;

  // Next-state, counter, mode and error bookkeeping.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    accept   = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
    last_bit = (cnt_q == CNT_W'(CHAIN_LENGTH - 1));

    case (state_q)
      IDLE, DONE: state_d = accept ? CAP1 : IDLE;
      CAP1:       state_d = abort ? DONE : CAP2;
      CAP2:       state_d = abort ? DONE : SHIFT;
      SHIFT:      state_d = abort ? DONE : (last_bit ? UPD : SHIFT);
      UPD:        state_d = DONE;
      default:    state_d = IDLE;
    endcase

    if (accept) begin
      mode_d = test_mode_req;
      err_d  = 1'b0;
    end
    if (abort && ((state_q == CAP1) || (state_q == CAP2) || (state_q == SHIFT))) begin
      err_d = 1'b1;
    end

    if (state_q == CAP2) begin
      cnt_d = '0;
    end else if ((state_q == SHIFT) && !last_bit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Chain is shifted MSB first, so cell CHAIN_LENGTH-1-cnt is on the wire.
    tdi_idx = IDX_W'(CHAIN_LENGTH - 1) - IDX_W'(cnt_d);
    rd_idx  = IDX_W'(CHAIN_LENGTH - 1) - IDX_W'(cnt_q);
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      bsc_control <= '0;
      bsc_tdi     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        wr_q <= wr_data;
      end
      // Every edge with shift asserted moves one bit out of the chain.
      if (state_q == SHIFT) begin
        rd_data[rd_idx] <= bsc_tdo;
      end
      busy        <= (state_d == CAP1) || (state_d == CAP2) ||
                     (state_d == SHIFT) || (state_d == UPD);
      done        <= (state_d == DONE);
      err         <= (state_d == DONE) && err_d;
      bsc_control <= bsc_ctl(state_d, mode_d);
      bsc_tdi     <= (state_d == SHIFT) ? wr_q[tdi_idx] : 1'b0;
    end
  end

endmodule
